// File: rtl/qeciphy_tx_framer.sv
// QECIPHY TX framer: slots payload beats into fixed frames led by an alignment word, idle-filling empty slots.
// Optional statistics counters are built when QECIPHY_TX_FRAMER_STATS_EN is defined.
module qeciphy_tx_framer #(
    parameter int unsigned PERIOD     = 64,
    parameter logic [63:0] ALIGN_WORD = 64'h0000_00BC_0000_00BC,
    parameter logic [63:0] IDLE_WORD  = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        enable_i,
    input  logic [63:0] s_tdata_i,
    input  logic        s_tvalid_i,
    output logic        s_tready_o,
    output logic [63:0] tdata_o,
    output logic        is_align_o,
    output logic        is_data_o,
    output logic [15:0] align_cnt_o,
    output logic [15:0] idle_cnt_o
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SLOT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PERIOD - 1);

    typedef enum logic {
        ST_DISABLED = 1'b0,
        ST_RUN      = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [DATA_W-1:0]   tdata_q, tdata_d;
    logic                is_align_q, is_align_d;
    logic                is_data_q, is_data_d;
    logic                slot_zero;
    logic                accept;

    assign slot_zero  = (slot_q == '0);
    // Slot 0 always carries the alignment word, so no beat can be taken there.
    assign s_tready_o = enable_i && (state_q == ST_RUN) && !slot_zero;
    assign accept     = s_tready_o && s_tvalid_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_DISABLED;
            slot_q     <= '0;
            tdata_q    <= IDLE_WORD;
            is_align_q <= 1'b0;
            is_data_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            tdata_q    <= tdata_d;
            is_align_q <= is_align_d;
            is_data_q  <= is_data_d;
        end
    end

    always_comb begin
        state_d    = ST_DISABLED;
        slot_d     = '0;
        tdata_d    = IDLE_WORD;
        is_align_d = 1'b0;
        is_data_d  = 1'b0;
        if (enable_i) begin
            state_d = ST_RUN;
            slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
            if (slot_zero) begin
                tdata_d    = ALIGN_WORD;
                is_align_d = 1'b1;
            end else if (accept) begin
                tdata_d   = s_tdata_i;
                is_data_d = 1'b1;
            end
        end
    end

    assign tdata_o    = tdata_q;
    assign is_align_o = is_align_q;
    assign is_data_o  = is_data_q;

`ifdef QECIPHY_TX_FRAMER_STATS_EN
    logic [CNT_W-1:0] align_cnt_q, align_cnt_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

    // Counters wrap naturally and only clear on reset.
    always_comb begin
        align_cnt_d = align_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        if (enable_i && slot_zero) begin
            align_cnt_d = align_cnt_q + CNT_W'(1);
        end
        if (enable_i && !slot_zero && !accept) begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            align_cnt_q <= '0;
            idle_cnt_q  <= '0;
        end else begin
            align_cnt_q <= align_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    assign align_cnt_o = align_cnt_q;
    assign idle_cnt_o  = idle_cnt_q;
`else
    assign align_cnt_o = CNT_W'(0);
    assign idle_cnt_o  = CNT_W'(0);
`endif

endmodule

// File: tb/tb_qeciphy_tx_framer.sv
// Scoreboard bench for qeciphy_tx_framer; reference model tracks enabled-cycle count modulo PERIOD.
module tb_qeciphy_tx_framer;

    localparam int unsigned P     = 64;
    localparam logic [63:0] ALIGN = 64'h0000_00BC_0000_00BC;
    localparam logic [63:0] IDLE  = 64'h0;
`ifdef QECIPHY_TX_FRAMER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [63:0] d;
        logic        a;
        logic        v;
        logic [15:0] ac;
        logic [15:0] ic;
    } exp_t;

    logic        clk;
    logic        rst_n_i;
    logic        enable_i;
    logic [63:0] s_tdata_i;
    logic        s_tvalid_i;
    logic        s_tready_o;
    logic [63:0] tdata_o;
    logic        is_align_o;
    logic        is_data_o;
    logic [15:0] align_cnt_o;
    logic [15:0] idle_cnt_o;

    qeciphy_tx_framer #(
        .PERIOD    (P),
        .ALIGN_WORD(ALIGN),
        .IDLE_WORD (IDLE)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n_i),
        .enable_i   (enable_i),
        .s_tdata_i  (s_tdata_i),
        .s_tvalid_i (s_tvalid_i),
        .s_tready_o (s_tready_o),
        .tdata_o    (tdata_o),
        .is_align_o (is_align_o),
        .is_data_o  (is_data_o),
        .align_cnt_o(align_cnt_o),
        .idle_cnt_o (idle_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    bit          started = 1'b0;

    int unsigned run_cnt = 0;
    logic [15:0] m_ac = '0;
    logic [15:0] m_ic = '0;
    logic [63:0] beat = '0;
    logic [63:0] next_inc = '0;
    bit          holding = 1'b0;
    bit          incr_mode = 1'b0;

    task automatic new_beat();
        if (incr_mode) begin
            beat     = next_inc;
            next_inc = next_inc + 64'd1;
        end else begin
            beat = {$urandom, $urandom};
        end
    endtask

    // One cycle of stimulus; the model decides what must be registered at the next edge.
    task automatic step(input logic r, input logic en, input int vmode);
        exp_t e;
        logic v;
        logic exp_rdy;
        @(negedge clk);
        if (holding) v = 1'b1;
        else if (vmode == 0) v = 1'b0;
        else if (vmode == 1) v = 1'b1;
        else v = 1'($urandom_range(0, 1));
        rst_n_i    = r;
        enable_i   = en;
        s_tvalid_i = v;
        s_tdata_i  = v ? beat : {$urandom, $urandom};
        #1;
        exp_rdy = en && ((run_cnt % P) != 0);
        checks++;
        if (s_tready_o !== exp_rdy) begin
            errors++;
            $display("FAIL ready t=%0t got %b want %b", $time, s_tready_o, exp_rdy);
        end
        e.d = IDLE;
        e.a = 1'b0;
        e.v = 1'b0;
        if (!r) begin
            m_ac    = '0;
            m_ic    = '0;
            run_cnt = 0;
        end else if (!en) begin
            run_cnt = 0;
        end else begin
            if ((run_cnt % P) == 0) begin
                e.d = ALIGN;
                e.a = 1'b1;
                if (STATS) m_ac = m_ac + 16'd1;
            end else if (v) begin
                e.d = beat;
                e.v = 1'b1;
            end else begin
                if (STATS) m_ic = m_ic + 16'd1;
            end
            run_cnt++;
        end
        e.ac = m_ac;
        e.ic = m_ic;
        if (exp_rdy && v) begin
            new_beat();
            holding = 1'b0;
        end else begin
            holding = v;
        end
        q.push_back(e);
        started = 1'b1;
    endtask

    // Monitor: pops one expectation per clock and compares registered outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty t=%0t", $time);
                end else begin
                    e = q.pop_front();
                    if ({tdata_o, is_align_o, is_data_o} !== {e.d, e.a, e.v}) begin
                        errors++;
                        $display("FAIL word t=%0t got %h a%b d%b want %h a%b d%b",
                                 $time, tdata_o, is_align_o, is_data_o, e.d, e.a, e.v);
                    end
                    checks++;
                    if ({align_cnt_o, idle_cnt_o} !== {e.ac, e.ic}) begin
                        errors++;
                        $display("FAIL counters t=%0t got %0d/%0d want %0d/%0d",
                                 $time, align_cnt_o, idle_cnt_o, e.ac, e.ic);
                    end
                end
            end
        end
    end

    initial begin
        rst_n_i    = 1'b0;
        enable_i   = 1'b0;
        s_tvalid_i = 1'b0;
        s_tdata_i  = '0;

        // Reset, then idle-only enabled stream for 130 cycles.
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 0);
        for (int i = 0; i < 130; i++) step(1'b1, 1'b1, 0);
        @(posedge clk);
        #2;
        checks++;
        if (align_cnt_o !== (STATS ? 16'd3 : 16'd0) || idle_cnt_o !== (STATS ? 16'd127 : 16'd0)) begin
            errors++;
            $display("FAIL idle_scenario_counts got %0d/%0d", align_cnt_o, idle_cnt_o);
        end

        // Back-to-back incrementing payload from a fresh enable.
        step(1'b1, 1'b0, 0);
        incr_mode = 1'b1;
        new_beat();
        for (int i = 0; i < 200; i++) step(1'b1, 1'b1, 1);

        // Random valid for 10k cycles with random payload.
        incr_mode = 1'b0;
        for (int i = 0; i < 10000; i++) step(1'b1, 1'b1, 2);

        // Drop enable at slot 30 for 5 cycles, then re-enable.
        while ((run_cnt % P) != 30) step(1'b1, 1'b1, 2);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2);
        for (int i = 0; i < 140; i++) step(1'b1, 1'b1, 2);

        // Reset pulse at slot 40 while valid is held high.
        while ((run_cnt % P) != 40) step(1'b1, 1'b1, 1);
        step(1'b0, 1'b1, 1);
        for (int i = 0; i < 70; i++) step(1'b1, 1'b1, 1);

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations got %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
